// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_e        : arbiter FSM state encoding
//   DEF_MAX_DM_STREAK  : default data grants allowed while a fetch is waiting
//   DEF_TIMEOUT        : default access cycles before an access is aborted
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_ACC = 2'd1,
    ST_DM_ACC = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_MAX_DM_STREAK = 3;
  localparam int unsigned DEF_TIMEOUT       = 15;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between an instruction-fetch port and a
// data port. Data has priority unless a fetch has waited MAX_DM_STREAK data
// grants. Accesses that see no mem_ack within TIMEOUT cycles are aborted and
// flag a sticky bus error.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   if_req/if_addr/if_flush    : fetch request, address, branch flush
//   if_ready/if_rdata          : fetch completion pulse and read data
//   dm_req/dm_we/dm_addr/dm_wdata : data request
//   dm_ready/dm_rdata          : data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata : memory request (registered)
//   mem_rdata/mem_ack          : memory response
//   stall_if                   : combinational fetch stall
//   bus_err                    : sticky timeout flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        bus_err
);

  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

  arb_state_e          state;
  logic [STREAK_W-1:0] streak;
  logic [TMO_W-1:0]    tmo;
  logic                discard;

  logic                if_req_m;
  logic                dm_req_m;
  logic                streak_max;
  logic                grant_if;
  logic                grant_dm;
  logic [TMO_W-1:0]    tmo_next;
  logic                tmo_hit;
  logic                discard_now;

  // Arbitration: a port in its ready cycle is masked so it is not re-granted.
  always_comb begin
    if_req_m    = if_req & ~if_ready;
    dm_req_m    = dm_req & ~dm_ready;
    streak_max  = (streak == STREAK_W'(MAX_DM_STREAK));
    grant_if    = (state == ST_IDLE) & if_req_m & ~if_flush & (~dm_req_m | streak_max);
    grant_dm    = (state == ST_IDLE) & dm_req_m & ~grant_if;
    tmo_next    = TMO_W'(tmo + TMO_W'(1));
    tmo_hit     = ~mem_ack & (tmo_next == TMO_W'(TIMEOUT));
    // A flush arriving in the completion cycle still kills the fetch.
    discard_now = discard | if_flush;
    stall_if    = if_req & ~if_ready & ~if_flush;
  end

  // FSM, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      streak    <= '0;
      tmo       <= '0;
      discard   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_ready  <= 1'b0;
      dm_rdata  <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      // Streak counts data grants that overtook a waiting fetch.
      if (!if_req || grant_if) begin
        streak <= '0;
      end else if (grant_dm && !streak_max) begin
        streak <= STREAK_W'(streak + STREAK_W'(1));
      end

      case (state)
        ST_IDLE: begin
          discard <= 1'b0;
          if (grant_if) begin
            state    <= ST_IF_ACC;
            tmo      <= '0;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end else if (grant_dm) begin
            state     <= ST_DM_ACC;
            tmo       <= '0;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end
        end

        ST_IF_ACC: begin
          if (if_flush) discard <= 1'b1;
          if (mem_ack || tmo_hit) begin
            state   <= ST_IDLE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            discard <= 1'b0;
            if (tmo_hit) bus_err <= 1'b1;
            if (!discard_now) begin
              if_ready <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : 32'h0;
            end
          end else begin
            tmo <= tmo_next;
          end
        end

        ST_DM_ACC: begin
          if (mem_ack || tmo_hit) begin
            state    <= ST_IDLE;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            dm_ready <= 1'b1;
            if (tmo_hit) bus_err <= 1'b1;
            if (!mem_we) dm_rdata <= mem_ack ? mem_rdata : 32'h0;
          end else begin
            tmo <= tmo_next;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;

  localparam int MAXS = 3;
  localparam int TMO  = 15;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ready (dm_ready),
    .dm_rdata (dm_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_if (stall_if),
    .bus_err  (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Behavioural model: who owns the memory, how long it has waited, and
  // what each port should be showing after every clock edge.
  int          m_owner;   // 0 nobody, 1 fetch, 2 data
  bit          m_store;
  int          m_age;
  int          m_streak;
  bit          m_discard;
  logic        e_if_ready, e_dm_ready, e_mem_en, e_mem_we, e_bus_err;
  logic [31:0] e_if_rdata, e_dm_rdata, e_mem_addr, e_mem_wdata;

  always @(posedge clk) begin
    bit ifw, dmw, fin, expired, killed;
    if (!rst_n) begin
      m_owner = 0; m_store = 0; m_age = 0; m_streak = 0; m_discard = 0;
      e_if_ready = 0; e_dm_ready = 0; e_mem_en = 0; e_mem_we = 0; e_bus_err = 0;
      e_if_rdata = 0; e_dm_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0;
    end else begin
      ifw = if_req && !e_if_ready;
      dmw = dm_req && !e_dm_ready;
      e_if_ready = 0;
      e_dm_ready = 0;
      if (m_owner == 0) begin
        m_discard = 0;
        if (ifw && !if_flush && (!dmw || m_streak == MAXS)) begin
          m_owner = 1; m_age = 0; m_streak = 0;
          e_mem_en = 1; e_mem_we = 0; e_mem_addr = if_addr;
        end else if (dmw) begin
          m_owner = 2; m_age = 0; m_store = dm_we;
          e_mem_en = 1; e_mem_we = dm_we; e_mem_addr = dm_addr; e_mem_wdata = dm_wdata;
          if (if_req && m_streak < MAXS) m_streak = m_streak + 1;
        end
      end else begin
        fin     = mem_ack;
        expired = !mem_ack && (m_age + 1 == TMO);
        killed  = m_discard || if_flush;
        if (fin || expired) begin
          if (expired) e_bus_err = 1;
          if (m_owner == 1) begin
            if (!killed) begin
              e_if_ready = 1;
              e_if_rdata = fin ? mem_rdata : 32'h0;
            end
          end else begin
            e_dm_ready = 1;
            if (!m_store) e_dm_rdata = fin ? mem_rdata : 32'h0;
          end
          m_owner = 0; e_mem_en = 0; e_mem_we = 0; m_discard = 0;
        end else begin
          m_age = m_age + 1;
          if (m_owner == 1 && if_flush) m_discard = 1;
        end
      end
      if (!if_req) m_streak = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) tick();
    checks++;
    if ({mem_en, mem_we, if_ready, dm_ready, bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {mem_en, mem_we, if_ready, dm_ready, bus_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h/%h expected all zero", mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h40;       // cycle 1: grant
    tick();                              // cycle 2: first access cycle
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL fetch_access: en=%b we=%b addr=%h expected 1 0 00000040", mem_en, mem_we, mem_addr);
    end
    checks++;
    if (stall_if !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall: got %b expected 1", stall_if);
    end
    tick();                              // cycle 3: ack
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick();                              // cycle 4: ready
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h12345678 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ready: ready=%b rdata=%h en=%b expected 1 12345678 0", if_ready, if_rdata, mem_en);
    end
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall_ready: got %b expected 0", stall_if);
    end
    if_req = 0; mem_ack = 0;
    tick();
    checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL fetch_pulse: ready=%b rdata=%h expected 0 12345678", if_ready, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL simul_data_first: en=%b addr=%h we=%b expected 1 00000100 0", mem_en, mem_addr, mem_we);
    end
    mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    tick();                              // dm_ready cycle, dm_req still high
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL simul_dm_ready: ready=%b rdata=%h expected 1 a5a5a5a5", dm_ready, dm_rdata);
    end
    mem_ack = 0;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL simul_fetch_next: en=%b addr=%h expected 1 00000200", mem_en, mem_addr);
    end
    dm_req = 0;
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'hCAFEF00D || dm_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_if_ready: ready=%b rdata=%h dm_ready=%b expected 1 cafef00d 0", if_ready, if_rdata, dm_ready);
    end
    if_req = 0; mem_ack = 0;
    tick();
  endtask

  // Flushing in each dm_ready cycle keeps the fetch waiting so data wins
  // repeatedly; after three data grants the fetch must be chosen.
  task automatic test_starvation();
    int n;
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 1; dm_addr = 32'h600; dm_wdata = 32'h11112222;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (mem_en !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (g < 3) begin
        if (mem_en !== 1'b1 || mem_addr !== 32'h600 || mem_we !== 1'b1 || mem_wdata !== 32'h11112222) begin
          errors++;
          $display("FAIL starve_grant%0d: en=%b addr=%h we=%b wdata=%h expected data store", g, mem_en, mem_addr, mem_we, mem_wdata);
        end
      end else begin
        if (mem_en !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL starve_grant%0d: en=%b addr=%h we=%b expected fetch 00000300", g, mem_en, mem_addr, mem_we);
        end
      end
      mem_ack = 1; mem_rdata = 32'h77778888;
      tick();
      mem_ack = 0;
      if (g < 3) begin
        if_flush = 1;
        tick();
        if_flush = 0;
      end
    end
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h77778888) begin
      errors++;
      $display("FAIL starve_if_ready: ready=%b rdata=%h expected 1 77778888", if_ready, if_rdata);
    end
    if_req = 0; dm_req = 0;
    tick();
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 32'h50;
    tick();
    if_flush = 1;
    tick();
    if_flush = 0; if_req = 0;
    mem_ack = 1; mem_rdata = 32'hDEADDEAD;
    tick();
    checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h77778888 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: ready=%b rdata=%h en=%b expected 0 77778888 0", if_ready, if_rdata, mem_en);
    end
    mem_ack = 0;
    if_req = 1; if_addr = 32'h80;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h80) begin
      errors++;
      $display("FAIL flush_next_grant: en=%b addr=%h expected 1 00000080", mem_en, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h0BADBEEF;
    tick();
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h0BADBEEF) begin
      errors++;
      $display("FAIL flush_next_ready: ready=%b rdata=%h expected 1 0badbeef", if_ready, if_rdata);
    end
    if_req = 0; mem_ack = 0;
    tick();
  endtask

  task automatic test_ack_at_limit();
    dm_req = 1; dm_we = 0; dm_addr = 32'h440;
    tick();                              // access cycle 1
    repeat (TMO - 1) tick();             // access cycle 15
    mem_ack = 1; mem_rdata = 32'h5555AAAA;
    tick();
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 32'h5555AAAA || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_at_limit: ready=%b rdata=%h bus_err=%b expected 1 5555aaaa 0", dm_ready, dm_rdata, bus_err);
    end
    dm_req = 0; mem_ack = 0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    tick();                              // access cycle 1
    n = 0;
    while (dm_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != TMO) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TMO);
    end
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 32'h0 || bus_err !== 1'b1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: ready=%b rdata=%h bus_err=%b en=%b expected 1 0 1 0", dm_ready, dm_rdata, bus_err, mem_en);
    end
    dm_req = 0;
    repeat (3) tick();
    checks++;
    if (bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: bus_err=%b expected 1", bus_err);
    end
  endtask

  task automatic test_reset_mid();
    dm_req = 1; dm_we = 1; dm_addr = 32'h700; dm_wdata = 32'h1;
    tick();
    rst_n = 0;
    tick();
    checks++;
    if (mem_en !== 1'b0 || dm_ready !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: en=%b ready=%b bus_err=%b expected 0 0 0", mem_en, dm_ready, bus_err);
    end
    rst_n = 1; dm_req = 0;
    mem_ack = 1;                         // ack with nobody granted must be ignored
    tick();
    mem_ack = 0;
    tick();
    checks++;
    if (dm_ready !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: ready=%b en=%b expected 0 0", dm_ready, mem_en);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      checks++;
      if (if_ready !== e_if_ready || if_rdata !== e_if_rdata) begin
        errors++;
        $display("FAIL rand_if c=%0d: ready=%b rdata=%h expected %b %h", c, if_ready, if_rdata, e_if_ready, e_if_rdata);
      end
      checks++;
      if (dm_ready !== e_dm_ready || dm_rdata !== e_dm_rdata) begin
        errors++;
        $display("FAIL rand_dm c=%0d: ready=%b rdata=%h expected %b %h", c, dm_ready, dm_rdata, e_dm_ready, e_dm_rdata);
      end
      checks++;
      if (mem_en !== e_mem_en || bus_err !== e_bus_err) begin
        errors++;
        $display("FAIL rand_en c=%0d: en=%b bus_err=%b expected %b %b", c, mem_en, bus_err, e_mem_en, e_bus_err);
      end
      if (e_mem_en) begin
        checks++;
        if (mem_addr !== e_mem_addr || mem_we !== e_mem_we || (e_mem_we && mem_wdata !== e_mem_wdata)) begin
          errors++;
          $display("FAIL rand_mem c=%0d: addr=%h we=%b wdata=%h expected %h %b %h", c, mem_addr, mem_we, mem_wdata, e_mem_addr, e_mem_we, e_mem_wdata);
        end
      end
      // Requesters: hold a request until served, redirect fetches on flush.
      if_flush = ($urandom_range(0, 15) == 0);
      if (if_flush) begin
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!if_req || e_if_ready) begin
        if_req  = ($urandom_range(0, 2) == 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req || e_dm_ready) begin
        dm_req   = ($urandom_range(0, 2) == 0);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
      end
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      checks++;
      #1;
      if (stall_if !== (if_req & ~e_if_ready & ~if_flush)) begin
        errors++;
        $display("FAIL rand_stall c=%0d: got %b expected %b", c, stall_if, if_req & ~e_if_ready & ~if_flush);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
